// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types: boot-loader FSM states, default register-interface structs and
// regmap offsets used to build boot-time configuration tables.
package rv_iopmp_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDone,
    StError
  } cfg_loader_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } iopmp_reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } iopmp_reg_rsp_t;

  // Byte offsets into the IOPMP regmap
  localparam logic [31:0] RegHwcfg0Offset = 32'h0000_0008;
  localparam logic [31:0] RegMdcfgOffset  = 32'h0000_0800;
  localparam logic [31:0] RegSrcmdOffset  = 32'h0000_1000;
  localparam logic [31:0] RegEntryOffset  = 32'h0000_2000;

  // HWCFG0 bit positions for the final enable/lock write of a table
  localparam int unsigned Hwcfg0EnableBit = 31;
  localparam int unsigned Hwcfg0LockBit   = 30;

endpackage

// File: rtl/rv_iopmp_cfg_loader.sv
// Boot-time register initiator: replays a fixed (addr, data) table into the IOPMP regmap,
// optionally verifies each write, then hands the port back to the external config path.
module rv_iopmp_cfg_loader
  import rv_iopmp_pkg::*;
#(
  parameter int unsigned NUM_WRITES     = 4,
  parameter int unsigned REG_ADDR_WIDTH = 32,
  parameter int unsigned REG_DATA_WIDTH = 32,
  parameter logic [NUM_WRITES-1:0][REG_ADDR_WIDTH-1:0] INIT_ADDR   = '0,
  parameter logic [NUM_WRITES-1:0][REG_DATA_WIDTH-1:0] INIT_DATA   = '0,
  parameter logic [NUM_WRITES-1:0][REG_DATA_WIDTH-1:0] VERIFY_MASK = '1,
  parameter int unsigned TIMEOUT        = 255,
  parameter type reg_req_t              = rv_iopmp_pkg::iopmp_reg_req_t,
  parameter type reg_rsp_t              = rv_iopmp_pkg::iopmp_reg_rsp_t
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  reg_req_t                      ext_req_i,
  output reg_rsp_t                      ext_rsp_o,
  output reg_req_t                      cfg_req_o,
  input  reg_rsp_t                      cfg_rsp_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          error_o,
  output logic [$clog2(NUM_WRITES):0]   err_idx_o
);

  localparam int unsigned IdxW = (NUM_WRITES > 1) ? $clog2(NUM_WRITES) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam int unsigned ErrW = $clog2(NUM_WRITES) + 1;

  cfg_loader_state_e r_state_q, r_state_d;
  logic [IdxW-1:0]   r_idx_q, r_idx_d;
  logic [CntW-1:0]   r_cnt_q, r_cnt_d;
  logic [ErrW-1:0]   r_err_idx_q, r_err_idx_d;

  logic              w_busy;
  logic              w_last;
  logic              w_verify;
  logic              w_mismatch;
  logic              w_expired;
  logic [CntW-1:0]   w_cnt_inc;
  reg_req_t          w_ldr_req;

  assign w_busy     = (r_state_q == StWrite) || (r_state_q == StRead);
  assign w_last     = (r_idx_q == IdxW'(NUM_WRITES - 1));
  assign w_verify   = |VERIFY_MASK[r_idx_q];
  assign w_mismatch = |((cfg_rsp_i.rdata ^ INIT_DATA[r_idx_q]) & VERIFY_MASK[r_idx_q]);
  assign w_cnt_inc  = r_cnt_q + CntW'(1);
  // The access times out after TIMEOUT cycles of valid without ready
  assign w_expired  = (w_cnt_inc == CntW'(TIMEOUT));

  // Loader request depends only on state/idx so it stays stable across wait states
  always_comb begin
    w_ldr_req       = '0;
    w_ldr_req.valid = w_busy;
    w_ldr_req.write = (r_state_q == StWrite);
    w_ldr_req.addr  = INIT_ADDR[r_idx_q];
    w_ldr_req.wdata = INIT_DATA[r_idx_q];
    w_ldr_req.wstrb = '1;
  end

  always_comb begin
    if (w_busy) begin
      cfg_req_o = w_ldr_req;
      ext_rsp_o = '0;
    end else begin
      cfg_req_o = ext_req_i;
      ext_rsp_o = cfg_rsp_i;
    end
  end

  always_comb begin
    r_state_d   = r_state_q;
    r_idx_d     = r_idx_q;
    r_cnt_d     = r_cnt_q;
    r_err_idx_d = r_err_idx_q;
    unique case (r_state_q)
      StIdle: begin
        if (start_i) begin
          r_state_d = StWrite;
          r_idx_d   = '0;
          r_cnt_d   = '0;
        end
      end
      StWrite, StRead: begin
        if (cfg_rsp_i.ready) begin
          r_cnt_d = '0;
          if (cfg_rsp_i.error || ((r_state_q == StRead) && w_mismatch)) begin
            r_state_d   = StError;
            r_err_idx_d = ErrW'(r_idx_q);
          end else if ((r_state_q == StWrite) && w_verify) begin
            r_state_d = StRead;
          end else if (w_last) begin
            r_state_d = StDone;
          end else begin
            r_state_d = StWrite;
            r_idx_d   = r_idx_q + IdxW'(1);
          end
        end else if (w_expired) begin
          r_state_d              = StError;
          r_err_idx_d            = ErrW'(r_idx_q);
          r_err_idx_d[ErrW-1]    = 1'b1;
        end else begin
          r_cnt_d = w_cnt_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q   <= StIdle;
      r_idx_q     <= '0;
      r_cnt_q     <= '0;
      r_err_idx_q <= '0;
    end else begin
      r_state_q   <= r_state_d;
      r_idx_q     <= r_idx_d;
      r_cnt_q     <= r_cnt_d;
      r_err_idx_q <= r_err_idx_d;
    end
  end

  assign busy_o    = w_busy;
  assign done_o    = (r_state_q == StDone);
  assign error_o   = (r_state_q == StError);
  assign err_idx_o = r_err_idx_q;

endmodule

// File: tb/tb_rv_iopmp_cfg_loader.sv
// Directed bench for rv_iopmp_cfg_loader with a small behavioural regmap on the cfg port.
module tb_rv_iopmp_cfg_loader;
  import rv_iopmp_pkg::*;

  localparam logic [3:0][31:0] TAddr = {32'h1C, 32'h18, 32'h14, 32'h10};
  localparam logic [3:0][31:0] TData = {32'h0000_0001, 32'h0BAD_F00D, 32'h0000_00AB,
                                        32'hDEAD_BEEF};
  localparam logic [3:0][31:0] TMask = {32'hFFFF_FFFF, 32'h0, 32'h0000_00FF, 32'h0};

  logic           clk;
  logic           rst_ni;
  logic           start_i;
  iopmp_reg_req_t ext_req;
  iopmp_reg_rsp_t ext_rsp;
  iopmp_reg_req_t cfg_req;
  iopmp_reg_rsp_t rsp;
  logic           busy, done, error;
  logic [2:0]     err_idx;

  int n_assert = 0;
  int n_fail   = 0;

  // Regmap model controls
  logic [31:0] mem [16];
  int          ready_mode;  // 0: always ready, 1: never ready, 2: ready after 3 wait cycles
  logic [31:0] rd_flip;     // corrupts readback of address 0x14
  logic        err_en;
  logic [31:0] err_addr;
  logic        model_clr;
  int          hold_cnt;
  int          wr3_cnt;

  rv_iopmp_cfg_loader #(
    .NUM_WRITES  (4),
    .INIT_ADDR   (TAddr),
    .INIT_DATA   (TData),
    .VERIFY_MASK (TMask),
    .TIMEOUT     (4)
  ) u_dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .ext_req_i (ext_req),
    .ext_rsp_o (ext_rsp),
    .cfg_req_o (cfg_req),
    .cfg_rsp_i (rsp),
    .busy_o    (busy),
    .done_o    (done),
    .error_o   (error),
    .err_idx_o (err_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    rsp       = '0;
    rsp.rdata = mem[cfg_req.addr[5:2]] ^ ((cfg_req.addr == 32'h14) ? rd_flip : 32'h0);
    if (ready_mode == 0)      rsp.ready = 1'b1;
    else if (ready_mode == 1) rsp.ready = 1'b0;
    else                      rsp.ready = (hold_cnt == 3);
    rsp.error = err_en && cfg_req.valid && cfg_req.write && (cfg_req.addr == err_addr);
  end

  always_ff @(posedge clk) begin
    if (model_clr) begin
      hold_cnt <= 0;
      wr3_cnt  <= 0;
    end else begin
      if (cfg_req.valid && !rsp.ready) hold_cnt <= hold_cnt + 1;
      else                             hold_cnt <= 0;
      if (cfg_req.valid && rsp.ready && !rsp.error && cfg_req.write) begin
        mem[cfg_req.addr[5:2]] <= cfg_req.wdata;
        if (cfg_req.addr == 32'h1C) wr3_cnt <= wr3_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_ni    = 1'b0;
    model_clr = 1'b1;
    tick();
    rst_ni    = 1'b1;
    model_clr = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] eaddr [6];
    logic        ewr   [6];
    eaddr = '{32'h10, 32'h14, 32'h14, 32'h18, 32'h1C, 32'h1C};
    ewr   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    rst_ni = 1'b0; start_i = 1'b0; ext_req = '0;
    ready_mode = 0; rd_flip = '0; err_en = 1'b0; err_addr = '0; model_clr = 1'b1;
    tick(); tick();

    // Reset state and passthrough
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_err_idx", err_idx, 3'd0);
    ext_req = '{addr: 32'h20, write: 1'b1, wdata: 32'hCAFE, wstrb: 4'hF, valid: 1'b0};
    #1;
    check("rst_pass_req", cfg_req, ext_req);
    check("rst_pass_rsp", ext_rsp, rsp);
    rst_ni = 1'b1; model_clr = 1'b0; ext_req = '0;
    tick();

    // Full run with an external write stalled behind it
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    ext_req = '{addr: 32'h3C, write: 1'b1, wdata: 32'h55, wstrb: 4'hF, valid: 1'b1};
    #1;
    for (int k = 0; k < 6; k++) begin
      check("run_busy", busy, 1'b1);
      check("run_addr", cfg_req.addr, eaddr[k]);
      check("run_write", cfg_req.write, ewr[k]);
      check("run_ext_stall", ext_rsp.ready, 1'b0);
      if (ewr[k]) check("run_wdata", cfg_req.wdata, TData[(eaddr[k] - 32'h10) >> 2]);
      tick();
    end
    check("run_done", done, 1'b1);
    check("run_busy_fall", busy, 1'b0);
    check("run_no_error", error, 1'b0);
    check("run_pass_req", cfg_req, ext_req);
    check("run_ext_ready", ext_rsp.ready, 1'b1);
    tick();
    ext_req = '0;
    check("ext_write_landed", mem[15], 32'h55);
    check("mem_entry0", mem[4], 32'hDEAD_BEEF);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    #1;
    check("restart_ignored_busy", busy, 1'b0);
    check("restart_ignored_done", done, 1'b1);
    check("restart_no_req", cfg_req.valid, 1'b0);

    // Wait states with a masked readback that differs only outside the mask
    do_reset();
    ready_mode = 2; rd_flip = 32'h1234_5600;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("wait_busy", busy, 1'b1);
      check("wait_addr", cfg_req.addr, 32'h10);
      check("wait_wdata", cfg_req.wdata, 32'hDEAD_BEEF);
      check("wait_write", cfg_req.write, 1'b1);
      tick();
    end
    for (int i = 0; i < 40 && !(done || error); i++) tick();
    check("wait_done", done, 1'b1);
    check("wait_no_error", error, 1'b0);

    // Readback mismatch on entry 1
    do_reset();
    ready_mode = 0; rd_flip = 32'h0000_0007;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick();
    check("mm_read_phase", cfg_req.write, 1'b0);
    check("mm_read_addr", cfg_req.addr, 32'h14);
    tick();
    check("mm_error", error, 1'b1);
    check("mm_err_idx", err_idx, 3'd1);
    check("mm_no_done", done, 1'b0);
    check("mm_busy", busy, 1'b0);

    // Slave error on the write of entry 2
    do_reset();
    rd_flip = '0; err_en = 1'b1; err_addr = 32'h18;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick(); tick();
    check("serr_addr", cfg_req.addr, 32'h18);
    tick();
    check("serr_error", error, 1'b1);
    check("serr_err_idx", err_idx, 3'd2);
    check("serr_busy", busy, 1'b0);
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    #1;
    check("serr_restart_busy", busy, 1'b0);
    check("serr_no_entry3", wr3_cnt, 0);
    check("serr_hold_idx", err_idx, 3'd2);
    err_en = 1'b0;

    // Timeout with ready never asserted
    do_reset();
    ready_mode = 1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("to_busy", busy, 1'b1);
      check("to_valid", cfg_req.valid, 1'b1);
      check("to_not_yet", error, 1'b0);
      tick();
    end
    check("to_error", error, 1'b1);
    check("to_err_idx", err_idx, 3'b100);
    check("to_busy_fall", busy, 1'b0);

    // Reset in the middle of the table, then replay
    do_reset();
    ready_mode = 0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    check("mid_idx1_addr", cfg_req.addr, 32'h14);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_error", error, 1'b0);
    check("mid_rst_err_idx", err_idx, 3'd0);
    check("mid_rst_pass", cfg_req, ext_req);
    tick();
    rst_ni = 1'b1;
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("replay_busy", busy, 1'b1);
    check("replay_addr", cfg_req.addr, 32'h10);
    check("replay_write", cfg_req.write, 1'b1);
    for (int i = 0; i < 20 && !(done || error); i++) tick();
    check("replay_done", done, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
